mem_stage: RTL and testbench

- Memory-access stage of the 5-stage pipeline.
- Sits directly downstream of the EX/MEM latch and consumes its registered control and data outputs (mem_write_reg, mem_read_reg, ALU result, store data).
- Holds the data memory and performs byte, half-word or word loads and stores with misalignment checking.
- Drives the MEM/WB latch outputs consumed by write-back.

---
 rtl/mem_stage_if.sv | 56 +++++
 rtl/mem_stage.sv | 135 +++++++++++++
 tb/tb_mem_stage.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// EX/MEM to MEM/WB bundle for the memory-access stage.
// master: pipeline side (drives EX/MEM, observes WB); slave: the stage.
interface mem_stage_if;
  logic        mem_write_reg;
  logic        mem_read_reg;
  logic        mem_to_reg_reg;
  logic        reg_write_reg;
  logic [1:0]  size_reg;
  logic        unsigned_reg;
  logic [31:0] alu_result_reg;
  logic [31:0] write_data_reg;
  logic [4:0]  write_reg_reg;

  logic [31:0] read_data_wb;
  logic [31:0] alu_result_wb;
  logic [4:0]  write_reg_wb;
  logic        reg_write_wb;
  logic        mem_to_reg_wb;
  logic        misalign_wb;

  modport master (
    output mem_write_reg,
    output mem_read_reg,
    output mem_to_reg_reg,
    output reg_write_reg,
    output size_reg,
    output unsigned_reg,
    output alu_result_reg,
    output write_data_reg,
    output write_reg_reg,
    input  read_data_wb,
    input  alu_result_wb,
    input  write_reg_wb,
    input  reg_write_wb,
    input  mem_to_reg_wb,
    input  misalign_wb
  );

  modport slave (
    input  mem_write_reg,
    input  mem_read_reg,
    input  mem_to_reg_reg,
    input  reg_write_reg,
    input  size_reg,
    input  unsigned_reg,
    input  alu_result_reg,
    input  write_data_reg,
    input  write_reg_reg,
    output read_data_wb,
    output alu_result_wb,
    output write_reg_wb,
    output reg_write_wb,
    output mem_to_reg_wb,
    output misalign_wb
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: little-endian data memory with byte/half/word
// loads and stores, misalignment detection, and the MEM/WB latch.
module mem_stage #(
  parameter int DEPTH     = 256,
  parameter int ADDR_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  mem_stage_if.slave  bus
);

  logic [31:0] r_mem [DEPTH];

  logic [31:0] r_read_data;
  logic [31:0] r_alu_result;
  logic [4:0]  r_write_reg;
  logic        r_reg_write;
  logic        r_mem_to_reg;
  logic        r_misalign;

  logic [ADDR_BITS-1:0] w_idx;
  logic [1:0]  w_off;
  logic        w_byte;
  logic        w_half;
  logic        w_word;
  logic        w_access;
  logic        w_misalign;
  logic        w_advance;
  logic        w_store;
  logic [31:0] w_rword;
  logic [7:0]  w_rbyte;
  logic [15:0] w_rhalf;
  logic [31:0] w_load;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;

  // Upper address bits are dropped so accesses wrap modulo DEPTH words.
  assign w_idx = bus.alu_result_reg[ADDR_BITS+1:2];
  assign w_off = bus.alu_result_reg[1:0];

  always_comb begin
    w_byte = 1'b0;
    w_half = 1'b0;
    w_word = 1'b0;
    unique case (bus.size_reg)
      2'b00:   w_byte = 1'b1;
      2'b01:   w_half = 1'b1;
      default: w_word = 1'b1;
    endcase
  end

  assign w_access   = bus.mem_read_reg | bus.mem_write_reg;
  assign w_misalign = w_access &
                      ((w_half & w_off[0]) |
                       (w_word & (|w_off)));

  assign w_advance = ~stall & ~flush;
  assign w_store   = w_advance & bus.mem_write_reg & ~w_misalign;

  assign w_rword = r_mem[w_idx];
  assign w_rbyte = w_rword[{w_off, 3'b000} +: 8];
  assign w_rhalf = w_off[1] ? w_rword[31:16] : w_rword[15:0];

  always_comb begin
    w_load = w_rword;
    unique case (1'b1)
      w_byte: w_load = {{24{~bus.unsigned_reg & w_rbyte[7]}}, w_rbyte};
      w_half: w_load = {{16{~bus.unsigned_reg & w_rhalf[15]}}, w_rhalf};
      default: w_load = w_rword;
    endcase
  end

  // Replicate store data across lanes; the byte enables pick the live ones.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = bus.write_data_reg;
    unique case (1'b1)
      w_byte: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{bus.write_data_reg[7:0]}};
      end
      w_half: begin
        w_be    = w_off[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{bus.write_data_reg[15:0]}};
      end
      default: w_be = 4'b1111;
    endcase
  end

  // Contents survive reset; only a store pending at a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (!rst && w_store) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_read_data  <= 32'd0;
      r_alu_result <= 32'd0;
      r_write_reg  <= 5'd0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_misalign   <= 1'b0;
    end else if (flush) begin
      r_read_data  <= 32'd0;
      r_alu_result <= 32'd0;
      r_write_reg  <= 5'd0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_misalign   <= 1'b0;
    end else if (!stall) begin
      r_alu_result <= bus.alu_result_reg;
      r_write_reg  <= bus.write_reg_reg;
      r_misalign   <= w_misalign;
      r_reg_write  <= bus.reg_write_reg & ~w_misalign;
      r_mem_to_reg <= bus.mem_to_reg_reg & ~w_misalign;
      r_read_data  <= w_misalign ? 32'd0 : w_load;
    end
  end

  assign bus.read_data_wb  = r_read_data;
  assign bus.alu_result_wb = r_alu_result;
  assign bus.write_reg_wb  = r_write_reg;
  assign bus.reg_write_wb  = r_reg_write;
  assign bus.mem_to_reg_wb = r_mem_to_reg;
  assign bus.misalign_wb   = r_misalign;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: byte-array reference model, per-cycle compare,
// directed literal checks and randomized traffic.
module tb_mem_stage;
  localparam int DEPTH = 256;
  localparam int NB    = DEPTH * 4;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic stall = 1'b0;
  logic flush = 1'b0;

  mem_stage_if bus();

  mem_stage #(.DEPTH(DEPTH), .ADDR_BITS(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .stall(stall),
    .flush(flush),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;
  bit cmp_on = 1'b0;

  logic [7:0]  mm [NB];
  logic [31:0] e_rd;
  logic [31:0] e_alu;
  logic [4:0]  e_wreg;
  logic        e_rw;
  logic        e_m2r;
  logic        e_mis;

  int          m_nb;
  int          m_ba;
  logic [31:0] m_v;
  bit          m_mis;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: byte-addressed array, sizes as byte counts.
  always @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      e_rd = 0; e_alu = 0; e_wreg = 0;
      e_rw = 0; e_m2r = 0; e_mis = 0;
    end else if (!stall) begin
      m_nb  = (bus.size_reg == 2'd0) ? 1 :
              (bus.size_reg == 2'd1) ? 2 : 4;
      m_ba  = int'(bus.alu_result_reg % 32'(NB));
      m_mis = (bus.mem_read_reg || bus.mem_write_reg) &&
              (m_ba % m_nb != 0);
      m_v = 0;
      for (int k = 0; k < m_nb; k++)
        m_v = m_v | (32'(mm[(m_ba + k) % NB]) << (8 * k));
      if (!bus.unsigned_reg && m_nb < 4 && m_v[8*m_nb-1] === 1'b1)
        m_v = m_v | (32'hFFFF_FFFF << (8 * m_nb));
      e_alu  = bus.alu_result_reg;
      e_wreg = bus.write_reg_reg;
      e_mis  = m_mis;
      e_rw   = bus.reg_write_reg && !m_mis;
      e_m2r  = bus.mem_to_reg_reg && !m_mis;
      e_rd   = m_mis ? 32'd0 : m_v;
      if (bus.mem_write_reg && !m_mis)
        for (int k = 0; k < m_nb; k++)
          mm[(m_ba + k) % NB] = bus.write_data_reg[8*k +: 8];
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("alu_result_wb", bus.alu_result_wb, e_alu);
      chk("write_reg_wb", 32'(bus.write_reg_wb), 32'(e_wreg));
      chk("reg_write_wb", 32'(bus.reg_write_wb), 32'(e_rw));
      chk("mem_to_reg_wb", 32'(bus.mem_to_reg_wb), 32'(e_m2r));
      chk("misalign_wb", 32'(bus.misalign_wb), 32'(e_mis));
      if (e_m2r || e_mis)
        chk("read_data_wb", bus.read_data_wb, e_rd);
    end
  end

  task automatic op(input bit wr, input bit rd, input bit m2r,
                    input bit rw, input logic [1:0] sz, input bit uns,
                    input logic [31:0] a, input logic [31:0] wd,
                    input logic [4:0] wreg, input bit st, input bit fl);
    bus.mem_write_reg  = wr;
    bus.mem_read_reg   = rd;
    bus.mem_to_reg_reg = m2r;
    bus.reg_write_reg  = rw;
    bus.size_reg       = sz;
    bus.unsigned_reg   = uns;
    bus.alu_result_reg = a;
    bus.write_data_reg = wd;
    bus.write_reg_reg  = wreg;
    stall = st;
    flush = fl;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic sw(input logic [31:0] a, input logic [31:0] d,
                    input logic [1:0] sz);
    op(1, 0, 0, 0, sz, 0, a, d, 5'd0, 0, 0);
  endtask

  task automatic lw(input logic [31:0] a, input logic [1:0] sz,
                    input bit uns, input logic [4:0] wreg);
    op(0, 1, 1, 1, sz, uns, a, 32'd0, wreg, 0, 0);
  endtask

  task automatic chk_zero(string nm);
    chk({nm, ".rd"}, bus.read_data_wb, 32'd0);
    chk({nm, ".alu"}, bus.alu_result_wb, 32'd0);
    chk({nm, ".wreg"}, 32'(bus.write_reg_wb), 32'd0);
    chk({nm, ".rw"}, 32'(bus.reg_write_wb), 32'd0);
    chk({nm, ".m2r"}, 32'(bus.mem_to_reg_wb), 32'd0);
    chk({nm, ".mis"}, 32'(bus.misalign_wb), 32'd0);
  endtask

  initial begin
    bus.mem_write_reg  = 0;
    bus.mem_read_reg   = 0;
    bus.mem_to_reg_reg = 0;
    bus.reg_write_reg  = 0;
    bus.size_reg       = 0;
    bus.unsigned_reg   = 0;
    bus.alu_result_reg = 0;
    bus.write_data_reg = 0;
    bus.write_reg_reg  = 0;
    #1 rst = 1'b1;
    cmp_on = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) sw(32'(i * 4), $urandom, 2'd2);

    sw(32'h10, 32'hDEAD_BEEF, 2'd2);
    lw(32'h10, 2'd2, 0, 5'd5);
    chk("word_load", bus.read_data_wb, 32'hDEAD_BEEF);
    chk("word_load.rw", 32'(bus.reg_write_wb), 32'd1);

    sw(32'h11, 32'h1234_5680, 2'd0);
    lw(32'h10, 2'd2, 0, 5'd5);
    chk("byte_store", bus.read_data_wb, 32'hDEAD_80EF);
    lw(32'h11, 2'd0, 0, 5'd5);
    chk("lb_signed", bus.read_data_wb, 32'hFFFF_FF80);
    lw(32'h11, 2'd0, 1, 5'd5);
    chk("lb_unsigned", bus.read_data_wb, 32'h0000_0080);
    lw(32'h12, 2'd1, 0, 5'd5);
    chk("lh_signed", bus.read_data_wb, 32'hFFFF_DEAD);

    sw(32'h20, 32'h1111_1111, 2'd2);
    op(1, 0, 0, 1, 2'd2, 0, 32'h21, 32'h1234_5678, 5'd3, 0, 0);
    chk("mis_store.mis", 32'(bus.misalign_wb), 32'd1);
    chk("mis_store.rw", 32'(bus.reg_write_wb), 32'd0);
    op(0, 0, 0, 0, 2'd2, 0, 32'h0, 32'h0, 5'd0, 0, 0);
    chk("mis_clear", 32'(bus.misalign_wb), 32'd0);
    lw(32'h20, 2'd2, 0, 5'd5);
    chk("mis_no_write", bus.read_data_wb, 32'h1111_1111);
    lw(32'h13, 2'd1, 0, 5'd5);
    chk("mis_lh.mis", 32'(bus.misalign_wb), 32'd1);
    chk("mis_lh.rd", bus.read_data_wb, 32'd0);

    sw(32'h30, 32'h0, 2'd2);
    lw(32'h10, 2'd2, 0, 5'd7);
    op(1, 0, 0, 0, 2'd2, 0, 32'h30, 32'hCAFE_F00D, 5'd0, 1, 0);
    op(1, 0, 0, 0, 2'd2, 0, 32'h30, 32'hCAFE_F00D, 5'd0, 1, 0);
    chk("stall.rd", bus.read_data_wb, 32'hDEAD_80EF);
    chk("stall.wreg", 32'(bus.write_reg_wb), 32'd7);
    chk("stall.alu", bus.alu_result_wb, 32'h10);
    op(1, 0, 0, 0, 2'd2, 0, 32'h30, 32'hCAFE_F00D, 5'd0, 1, 1);
    chk_zero("flush");
    op(1, 0, 0, 0, 2'd2, 0, 32'h30, 32'hCAFE_F00D, 5'd0, 0, 0);
    lw(32'h30, 2'd2, 0, 5'd5);
    chk("release_store", bus.read_data_wb, 32'hCAFE_F00D);

    sw(32'h400, 32'hA5A5_A5A5, 2'd2);
    lw(32'h000, 2'd2, 0, 5'd9);
    chk("wrap", bus.read_data_wb, 32'hA5A5_A5A5);

    #2 rst = 1'b1;
    #1 chk_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    lw(32'h000, 2'd2, 0, 5'd9);
    chk("mem_retained", bus.read_data_wb, 32'hA5A5_A5A5);

    repeat (1500) begin
      int r;
      bit wr, rd, rw;
      logic [31:0] a;
      r  = $urandom_range(0, 99);
      wr = (r < 30);
      rd = !wr && (r < 70);
      rw = rd || (!wr && ($urandom_range(0, 1) == 1));
      a  = ($urandom_range(0, 9) == 0) ? $urandom
                                       : 32'($urandom_range(0, 127));
      op(wr, rd, rd, rw, 2'($urandom_range(0, 3)),
         ($urandom_range(0, 1) == 1), a, $urandom,
         5'($urandom_range(0, 31)),
         ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
